bus_grant_arbiter: RTL and testbench



---
 rtl/bus_grant_arbiter_pkg.sv | 21 ++
 rtl/bus_grant_arbiter_if.sv | 20 ++
 rtl/bus_grant_arbiter_rr_pick.sv | 44 ++++
 rtl/bus_grant_arbiter.sv | 110 +++++++++++
 tb/tb_bus_grant_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_grant_arbiter_pkg.sv
// Shared definitions for the bus grant arbiter.
//   NUM_REQ / IDX_W : requester count and owner-index width (32 / 5)
//   state_t         : IDLE / OWN state encoding
//   idx_to_onehot   : binary owner index to one-hot grant vector
package bus_arb_pkg;

    localparam int NUM_REQ = 32;
    localparam int IDX_W   = 5;

    typedef logic state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_OWN  = 1'b1;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bus_grant_arbiter_if.sv
// Request/grant bundle between the control unit, the arbiter and the bus mux.
//   req         : per-requester level request
//   grant       : registered one-hot grant, zero when idle
//   grant_idx   : registered binary owner index, zero when idle
//   grant_valid : any grant asserted
//   grant_new   : one-cycle pulse on the first cycle of each new grant
// master = requester side, slave = arbiter side.
interface bus_grant_arbiter_if;
    import bus_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               grant_new;

    modport master (output req, input grant, grant_idx, grant_valid, grant_new);
    modport slave  (input req, output grant, grant_idx, grant_valid, grant_new);

endinterface

// File: rtl/bus_grant_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector
//   ptr        : highest-priority position for this scan
//   mask_idx   : requester to exclude (current owner) when mask_en is set
//   mask_en    : enable the owner mask
//   pick_idx   : first asserted request at or above ptr, wrapping 31 -> 0
//   pick_valid : at least one unmasked request exists
module rr_pick
    import bus_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic [IDX_W-1:0]   mask_idx,
    input  logic               mask_en,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               pick_valid
);

    logic [NUM_REQ-1:0] masked;
    logic [IDX_W-1:0]   offset;

    always_comb begin
        masked = req;
        if (mask_en) begin
            masked = req & ~idx_to_onehot(mask_idx);
        end
    end

    // Rotated view: offset i looks at requester (ptr + i) mod 32. Scanning
    // downward leaves the lowest set offset, i.e. the first one above ptr.
    always_comb begin
        offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (masked[IDX_W'(i) + ptr]) begin
                offset = IDX_W'(i);
            end
        end
    end

    assign pick_valid = |masked;
    // Un-rotate; the 5-bit add wraps modulo 32.
    assign pick_idx   = ptr + offset;

endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin bus arbiter with a maximum-hold limit.
//   clk : system clock, rising edge
//   clr : synchronous active-high reset
//   bus : request/grant bundle (slave side), all outputs registered
// MAX_HOLD : cycles an owner may keep the bus while others wait (0 = no limit)
// HOLD_W   : hold counter width, 2**HOLD_W > MAX_HOLD
module bus_grant_arbiter
    import bus_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
)
(
    input  logic                clk,
    input  logic                clr,
    bus_grant_arbiter_if.slave  bus
);

    // With no limit the counter just saturates at all-ones and never rotates.
    localparam logic [HOLD_W-1:0] HOLD_SAT =
        (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
    logic [NUM_REQ-1:0] grant_r, grant_nxt;
    logic [IDX_W-1:0]   idx_r, idx_nxt;
    logic               new_r, new_nxt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               take;

    // While owning, the owner is masked so pick_valid means "someone else waits".
    rr_pick u_pick (
        .req        (bus.req),
        .ptr        (ptr),
        .mask_idx   (idx_r),
        .mask_en    (state == ST_OWN),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            grant_r  <= '0;
            idx_r    <= '0;
            new_r    <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            grant_r  <= grant_nxt;
            idx_r    <= idx_nxt;
            new_r    <= new_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        grant_nxt = grant_r;
        idx_nxt   = idx_r;
        new_nxt   = 1'b0;
        take      = 1'b0;

        case (state)
            ST_IDLE: begin
                take = pick_valid;
            end
            default: begin
                if (!bus.req[idx_r]) begin
                    // Owner released: hand off directly, or go idle.
                    if (pick_valid) begin
                        take = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        hold_nxt  = '0;
                        grant_nxt = '0;
                        idx_nxt   = '0;
                    end
                end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_SAT) && pick_valid) begin
                    take = 1'b1;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
        endcase

        if (take) begin
            state_nxt = ST_OWN;
            grant_nxt = idx_to_onehot(pick_idx);
            idx_nxt   = pick_idx;
            new_nxt   = 1'b1;
            hold_nxt  = HOLD_W'(1);
            ptr_nxt   = pick_idx + IDX_W'(1);
        end
    end

    always_comb begin
        bus.grant       = grant_r;
        bus.grant_idx   = idx_r;
        bus.grant_valid = (state == ST_OWN);
        bus.grant_new   = new_r;
    end

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Scenario bench for bus_grant_arbiter: each task drives a table of per-cycle
// request/clear values, pushes the hand-derived expected outputs to a queue and
// pops/compares them one clock later. A negedge monitor checks the grant
// one-hot/index invariant on every cycle.
module tb_bus_grant_arbiter;

    typedef struct {
        logic [31:0] req;
        logic        clr;
        int          idx;
        logic        v;
        logic        n;
    } step_t;

    typedef struct packed {
        logic [31:0] grant;
        logic [4:0]  idx;
        logic        v;
        logic        n;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   inv_en = 1'b0;
    exp_t sbq[$];

    bus_grant_arbiter_if bif();

    bus_grant_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bif)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk_exp(int idx, logic v, logic n);
        exp_t e;
        e.grant = v ? (32'd1 << idx) : 32'd0;
        e.idx   = v ? 5'(idx) : 5'd0;
        e.v     = v;
        e.n     = n;
        return e;
    endfunction

    function automatic step_t st(logic [31:0] r, logic c, int idx, logic v, logic n);
        step_t s;
        s.req = r; s.clr = c; s.idx = idx; s.v = v; s.n = n;
        return s;
    endfunction

    // Invariant: grant zero or one-hot, index and valid consistent with it.
    always @(negedge clk) begin
        if (inv_en) begin
            checks++;
            if (bif.grant === 32'd0) begin
                if (bif.grant_idx !== 5'd0 || bif.grant_valid !== 1'b0 || bif.grant_new !== 1'b0) begin
                    failures++;
                    $display("FAIL invariant_idle t=%0t: idx=%0d valid=%b new=%b, required 0/0/0",
                             $time, bif.grant_idx, bif.grant_valid, bif.grant_new);
                end
            end else if (!$onehot(bif.grant) || bif.grant !== (32'd1 << bif.grant_idx) ||
                         bif.grant_valid !== 1'b1) begin
                failures++;
                $display("FAIL invariant_onehot t=%0t: grant=%h idx=%0d valid=%b, required one-hot matching idx with valid=1",
                         $time, bif.grant, bif.grant_idx, bif.grant_valid);
            end
        end
    end

    task automatic test_reset();
        step_t s[$];
        exp_t  e;
        s.push_back(st(32'h0, 1'b1, 0, 1'b0, 1'b0));
        s.push_back(st(32'h0, 1'b1, 0, 1'b0, 1'b0));
        s.push_back(st(32'h00000010, 1'b0, 4, 1'b1, 1'b1));
        s.push_back(st(32'h00000010, 1'b0, 4, 1'b1, 1'b0));
        s.push_back(st(32'h00000010, 1'b0, 4, 1'b1, 1'b0));
        s.push_back(st(32'h0, 1'b0, 0, 1'b0, 1'b0));
        foreach (s[k]) begin
            clr = s[k].clr; bif.req = s[k].req;
            sbq.push_back(mk_exp(s[k].idx, s[k].v, s[k].n));
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({bif.grant, bif.grant_idx, bif.grant_valid, bif.grant_new} !== e) begin
                failures++;
                $display("FAIL reset_single step %0d: grant=%h idx=%0d valid=%b new=%b, required grant=%h idx=%0d valid=%b new=%b",
                         k, bif.grant, bif.grant_idx, bif.grant_valid, bif.grant_new, e.grant, e.idx, e.v, e.n);
            end
            inv_en = 1'b1;
        end
    endtask

    task automatic test_round_robin();
        step_t s[$];
        exp_t  e;
        s.push_back(st(32'h0, 1'b1, 0, 1'b0, 1'b0));
        s.push_back(st(32'h80000003, 1'b0, 0, 1'b1, 1'b1));
        s.push_back(st(32'h80000002, 1'b0, 1, 1'b1, 1'b1));
        s.push_back(st(32'h80000001, 1'b0, 31, 1'b1, 1'b1));
        s.push_back(st(32'h00000003, 1'b0, 0, 1'b1, 1'b1));
        s.push_back(st(32'h0, 1'b0, 0, 1'b0, 1'b0));
        foreach (s[k]) begin
            clr = s[k].clr; bif.req = s[k].req;
            sbq.push_back(mk_exp(s[k].idx, s[k].v, s[k].n));
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({bif.grant, bif.grant_idx, bif.grant_valid, bif.grant_new} !== e) begin
                failures++;
                $display("FAIL round_robin step %0d: grant=%h idx=%0d valid=%b new=%b, required grant=%h idx=%0d valid=%b new=%b",
                         k, bif.grant, bif.grant_idx, bif.grant_valid, bif.grant_new, e.grant, e.idx, e.v, e.n);
            end
        end
    endtask

    task automatic test_hold_limit();
        step_t s[$];
        exp_t  e;
        s.push_back(st(32'h0, 1'b1, 0, 1'b0, 1'b0));
        s.push_back(st(32'h00000004, 1'b0, 2, 1'b1, 1'b1));
        s.push_back(st(32'h00000004, 1'b0, 2, 1'b1, 1'b0));
        // req[7] joins in the third ownership cycle; owner 2 still totals 8 cycles.
        for (int c = 3; c <= 8; c++) s.push_back(st(32'h00000084, 1'b0, 2, 1'b1, 1'b0));
        s.push_back(st(32'h00000084, 1'b0, 7, 1'b1, 1'b1));
        s.push_back(st(32'h00000084, 1'b0, 7, 1'b1, 1'b0));
        s.push_back(st(32'h0, 1'b1, 0, 1'b0, 1'b0));
        // Sole requester is never rotated off.
        s.push_back(st(32'h00000004, 1'b0, 2, 1'b1, 1'b1));
        for (int c = 0; c < 12; c++) s.push_back(st(32'h00000004, 1'b0, 2, 1'b1, 1'b0));
        s.push_back(st(32'h0, 1'b0, 0, 1'b0, 1'b0));
        foreach (s[k]) begin
            clr = s[k].clr; bif.req = s[k].req;
            sbq.push_back(mk_exp(s[k].idx, s[k].v, s[k].n));
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({bif.grant, bif.grant_idx, bif.grant_valid, bif.grant_new} !== e) begin
                failures++;
                $display("FAIL hold_limit step %0d: grant=%h idx=%0d valid=%b new=%b, required grant=%h idx=%0d valid=%b new=%b",
                         k, bif.grant, bif.grant_idx, bif.grant_valid, bif.grant_new, e.grant, e.idx, e.v, e.n);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        exp_t  e;
        s.push_back(st(32'h0, 1'b1, 0, 1'b0, 1'b0));
        s.push_back(st(32'h00000020, 1'b0, 5, 1'b1, 1'b1));
        s.push_back(st(32'h00000220, 1'b0, 5, 1'b1, 1'b0));
        s.push_back(st(32'h00000200, 1'b0, 9, 1'b1, 1'b1));
        s.push_back(st(32'h00000200, 1'b0, 9, 1'b1, 1'b0));
        s.push_back(st(32'h0, 1'b0, 0, 1'b0, 1'b0));
        foreach (s[k]) begin
            clr = s[k].clr; bif.req = s[k].req;
            sbq.push_back(mk_exp(s[k].idx, s[k].v, s[k].n));
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({bif.grant, bif.grant_idx, bif.grant_valid, bif.grant_new} !== e) begin
                failures++;
                $display("FAIL handoff step %0d: grant=%h idx=%0d valid=%b new=%b, required grant=%h idx=%0d valid=%b new=%b",
                         k, bif.grant, bif.grant_idx, bif.grant_valid, bif.grant_new, e.grant, e.idx, e.v, e.n);
            end
        end
    endtask

    task automatic test_clear_mid_grant();
        step_t s[$];
        exp_t  e;
        s.push_back(st(32'h0, 1'b1, 0, 1'b0, 1'b0));
        s.push_back(st(32'h00001000, 1'b0, 12, 1'b1, 1'b1));
        s.push_back(st(32'h00001000, 1'b0, 12, 1'b1, 1'b0));
        s.push_back(st(32'h00001000, 1'b1, 0, 1'b0, 1'b0));
        s.push_back(st(32'h00001000, 1'b0, 12, 1'b1, 1'b1));
        s.push_back(st(32'h0, 1'b0, 0, 1'b0, 1'b0));
        foreach (s[k]) begin
            clr = s[k].clr; bif.req = s[k].req;
            sbq.push_back(mk_exp(s[k].idx, s[k].v, s[k].n));
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({bif.grant, bif.grant_idx, bif.grant_valid, bif.grant_new} !== e) begin
                failures++;
                $display("FAIL clear_mid step %0d: grant=%h idx=%0d valid=%b new=%b, required grant=%h idx=%0d valid=%b new=%b",
                         k, bif.grant, bif.grant_idx, bif.grant_valid, bif.grant_new, e.grant, e.idx, e.v, e.n);
            end
        end
    endtask

    task automatic test_idle_return();
        step_t s[$];
        exp_t  e;
        s.push_back(st(32'h0, 1'b1, 0, 1'b0, 1'b0));
        s.push_back(st(32'h00100000, 1'b0, 20, 1'b1, 1'b1));
        s.push_back(st(32'h00100000, 1'b0, 20, 1'b1, 1'b0));
        s.push_back(st(32'h0, 1'b0, 0, 1'b0, 1'b0));
        s.push_back(st(32'h0, 1'b0, 0, 1'b0, 1'b0));
        foreach (s[k]) begin
            clr = s[k].clr; bif.req = s[k].req;
            sbq.push_back(mk_exp(s[k].idx, s[k].v, s[k].n));
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({bif.grant, bif.grant_idx, bif.grant_valid, bif.grant_new} !== e) begin
                failures++;
                $display("FAIL idle_return step %0d: grant=%h idx=%0d valid=%b new=%b, required grant=%h idx=%0d valid=%b new=%b",
                         k, bif.grant, bif.grant_idx, bif.grant_valid, bif.grant_new, e.grant, e.idx, e.v, e.n);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.req = '0;
        clr = 1'b1;
        test_reset();
        test_round_robin();
        test_hold_limit();
        test_back_to_back();
        test_clear_mid_grant();
        test_idle_return();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
